cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Line-refill controller for the N-way L1 cache; sits beside the replacement policy.
//  Accepts a miss with its victim way, fetches the full line from memory as BEATS beats,
//  writes each beat into the data array, then commits tag/valid.
//  Pulses fill/way/set back into the replacement policy so the filled way becomes MRU.
// PARAMETERS
//  SETS        128  sets per cache (power of 2)
//  WAYS        2    ways per set (power of 2, >=2)
//  ADDR_W      32   byte-address width
//  LINE_BYTES  32   line size (power of 2)
//  BEAT_BYTES  4    memory beat size; BEATS=LINE_BYTES/BEAT_BYTES, power of 2, >=2; DATA_W=8*BEAT_BYTES
//  TIMEOUT_CYC 255  stall limit, cycles; used only with CACHE_REFILL_TIMEOUT_EN
// PORTS
//  clk_i           in   1        clock
//  rst_i           in   1        async reset, active-high
//  miss_valid_i    in   1        miss request
//  miss_ready_o    out  1        controller idle, can accept a miss
//  miss_addr_i     in   ADDR_W   missing byte address
//  victim_way_i    in   log2(WAYS) way chosen by replacement policy
//  mem_req_valid_o out  1        line read request
//  mem_req_ready_i in   1        memory accepts request
//  mem_req_addr_o  out  ADDR_W   line-aligned address {tag,set,0}
//  mem_rsp_valid_i in   1        response beat valid
//  mem_rsp_ready_o out  1        accepting beats (=state BEATS)
//  mem_rsp_data_i  in   DATA_W   beat data
//  mem_rsp_err_i   in   1        beat carries bus error
//  data_we_o       out  1        data-array beat write
//  data_set_o/data_way_o/data_beat_o out log2(SETS)/log2(WAYS)/log2(BEATS)  write location
//  data_wdata_o    out  DATA_W   = mem_rsp_data_i
//  tag_we_o        out  1        tag-array write
//  tag_o           out  ADDR_W-OFF_W-SET_W  tag to write
//  tag_valid_o     out  1        valid bit to write
//  fill_o          out  1        to policy: way filled (1-cycle pulse)
//  fill_way_o/fill_set_o out log2(WAYS)/log2(SETS)  filled way / set
//  refill_done_o   out  1        1-cycle pulse, refill finished
//  refill_err_o    out  1        qualifies refill_done_o: line not installed
// BEHAVIOUR
//  OFF_W=log2(LINE_BYTES); set=addr[OFF_W+:SET_W]; tag=addr[ADDR_W-1:OFF_W+SET_W].
//  Reset: state IDLE, beat_cnt=0, err=0; all strobes/valids 0, miss_ready_o=1.
//  IDLE: miss_ready_o=1. On miss_valid_i: latch addr/set/tag/way;
//    same cycle tag_we_o=1, tag_valid_o=0 (invalidate victim) -> REQ.
//  REQ: mem_req_valid_o=1, addr stable until mem_req_ready_i -> BEATS, beat_cnt=0.
//  BEATS: each mem_rsp_valid_i: data_we_o=1 same cycle, data_beat_o=beat_cnt, cnt++.
//    mem_rsp_err_i ORs into sticky err; later beats still written.
//    Beat with cnt==BEATS-1 -> COMMIT (cnt wraps to 0). Gaps allowed, any length.
//  COMMIT (1 cycle): refill_done_o=1, tag_we_o=1 -> IDLE.
//    err=0: tag_valid_o=1, fill_o=1, refill_err_o=0. err=1: tag_valid_o=0, fill_o=0, refill_err_o=1.
//  miss_ready_o=0 outside IDLE: a miss presented during COMMIT is taken next cycle.
//  Latency miss accept -> done = 1 + req wait + BEATS beats (+gaps) + 1.
//  mem_rsp_valid_i outside BEATS ignored. Reset mid-refill: abandon, no done/fill pulse;
//    the victim stays invalid (invalidated at accept); memory side is reset together.
// CONFIGURATION
//  CACHE_REFILL_TIMEOUT_EN defined: stall counter cleared on state entry and every
//    handshake/beat; counts in REQ/BEATS; reaching TIMEOUT_CYC forces COMMIT with err=1
//    (mem_req_valid_o dropped). Not defined: no counter, waits indefinitely; TIMEOUT_CYC unused.
// TESTING
//  1 Defaults, miss 0x0000_1234 way1, 8 beats 0xA0..0xA7 -> req addr 0x1220,
//    writes set 0x11 way1 beats 0..7, COMMIT tag 0x1 valid 1, fill_o way1 set 0x11, done err=0.
//  2 mem_req_ready_i low 5 cycles -> mem_req_valid_o/addr held stable, no data_we_o.
//  3 err on beat 3 -> all 8 beats written; COMMIT tag_valid_o=0, fill_o=0, done+err=1.
//  4 beats every other cycle, miss_valid_i held high -> done 1 cycle after beat 7;
//    next miss accepted the cycle after COMMIT.
//  5 rst_i during beat 4 -> no done/fill; miss_ready_o=1 on release; next miss completes.
//  6 TIMEOUT_EN, TIMEOUT_CYC=16, no rsp after req -> done+err at 16th idle cycle, fill_o=0.

Source files
------------

// File: rtl/cache_refill_ctrl_if.sv
// cache_refill_ctrl_if: signal bundle between the line-refill controller and its neighbours
// Ports: miss request/ready, memory request and response beats, data-array beat write,
//   tag-array write, fill notification to the replacement policy, refill done/error.
// Modports: master = refill controller, slave = cache arrays, replacement policy and memory.
interface cache_refill_ctrl_if #(
  parameter int SETS       = 128,
  parameter int WAYS       = 2,
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32,
  parameter int BEAT_BYTES = 4
);
  localparam int SET_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int BEAT_W = $clog2(LINE_BYTES / BEAT_BYTES);
  localparam int TAG_W  = ADDR_W - OFF_W - SET_W;
  localparam int DATA_W = 8 * BEAT_BYTES;
  logic              miss_valid_i;
  logic              miss_ready_o;
  logic [ADDR_W-1:0] miss_addr_i;
  logic [WAY_W-1:0]  victim_way_i;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic              mem_rsp_valid_i;
  logic              mem_rsp_ready_o;
  logic [DATA_W-1:0] mem_rsp_data_i;
  logic              mem_rsp_err_i;
  logic              data_we_o;
  logic [SET_W-1:0]  data_set_o;
  logic [WAY_W-1:0]  data_way_o;
  logic [BEAT_W-1:0] data_beat_o;
  logic [DATA_W-1:0] data_wdata_o;
  logic              tag_we_o;
  logic [TAG_W-1:0]  tag_o;
  logic              tag_valid_o;
  logic              fill_o;
  logic [WAY_W-1:0]  fill_way_o;
  logic [SET_W-1:0]  fill_set_o;
  logic              refill_done_o;
  logic              refill_err_o;
  modport master (
    input  miss_valid_i, miss_addr_i, victim_way_i, mem_req_ready_i,
           mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
    output miss_ready_o, mem_req_valid_o, mem_req_addr_o, mem_rsp_ready_o,
           data_we_o, data_set_o, data_way_o, data_beat_o, data_wdata_o,
           tag_we_o, tag_o, tag_valid_o, fill_o, fill_way_o, fill_set_o,
           refill_done_o, refill_err_o
  );
  modport slave (
    output miss_valid_i, miss_addr_i, victim_way_i, mem_req_ready_i,
           mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
    input  miss_ready_o, mem_req_valid_o, mem_req_addr_o, mem_rsp_ready_o,
           data_we_o, data_set_o, data_way_o, data_beat_o, data_wdata_o,
           tag_we_o, tag_o, tag_valid_o, fill_o, fill_way_o, fill_set_o,
           refill_done_o, refill_err_o
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: refills one cache line beat by beat, then commits tag/valid and notifies the policy
// Ports: clk_i clock; rst_i async active-high reset; bus (cache_refill_ctrl_if.master) carries
//   the miss handshake, memory request/response, data/tag array writes, fill and done/error pulses.
// Optional: define CACHE_REFILL_TIMEOUT_EN to abort a refill stalled for TIMEOUT_CYC cycles.
module cache_refill_ctrl #(
  parameter int SETS        = 128,
  parameter int WAYS        = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_BYTES  = 32,
  parameter int BEAT_BYTES  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                 clk_i,
  input logic                 rst_i,
  cache_refill_ctrl_if.master bus
);
  localparam int SET_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int BEAT_W = $clog2(LINE_BYTES / BEAT_BYTES);
  localparam int TAG_W  = ADDR_W - OFF_W - SET_W;
  typedef enum logic [1:0] {IDLE, REQ, BEATS, COMMIT} state_e;
  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_q;
  logic [SET_W-1:0]  set_q;
  logic [WAY_W-1:0]  way_q;
  logic [BEAT_W-1:0] cnt_q;
  logic              err_q;
  logic              accept, beat, commit, tmo;
  logic [SET_W-1:0]  in_set;
  logic [TAG_W-1:0]  in_tag;
  logic              unused_off;
  assign in_set     = bus.miss_addr_i[OFF_W+:SET_W];
  assign in_tag     = bus.miss_addr_i[ADDR_W-1:OFF_W+SET_W];
  assign unused_off = ^bus.miss_addr_i[OFF_W-1:0];
  assign accept     = state_q == IDLE && bus.miss_valid_i;
  assign beat       = state_q == BEATS && bus.mem_rsp_valid_i;
  assign commit     = state_q == COMMIT;
`ifdef CACHE_REFILL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q;
  // tmo marks the last tolerated stall cycle; a beat arriving in that cycle still counts as progress
  assign tmo = (state_q == REQ || (state_q == BEATS && !bus.mem_rsp_valid_i)) &&
               stall_q == STALL_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) stall_q <= '0;
    else stall_q <= (state_d != state_q || beat || !(state_q == REQ || state_q == BEATS)) ? '0 : stall_q + 1'b1;
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.miss_valid_i ? REQ : IDLE;
      REQ:     state_d = tmo ? COMMIT : bus.mem_req_ready_i ? BEATS : REQ;
      BEATS:   state_d = (tmo || (beat && &cnt_q)) ? COMMIT : BEATS;
      default: state_d = IDLE;
    endcase
    bus.miss_ready_o    = state_q == IDLE;
    bus.mem_req_valid_o = state_q == REQ && !tmo;
    bus.mem_req_addr_o  = {tag_q, set_q, {OFF_W{1'b0}}};
    bus.mem_rsp_ready_o = state_q == BEATS;
    bus.data_we_o       = beat;
    // the victim is invalidated in the accept cycle, before its set/way/tag are registered
    bus.data_set_o      = accept ? in_set : set_q;
    bus.data_way_o      = accept ? bus.victim_way_i : way_q;
    bus.data_beat_o     = cnt_q;
    bus.data_wdata_o    = bus.mem_rsp_data_i;
    bus.tag_we_o        = accept || commit;
    bus.tag_o           = accept ? in_tag : tag_q;
    bus.tag_valid_o     = commit && !err_q;
    bus.fill_o          = commit && !err_q;
    bus.fill_way_o      = way_q;
    bus.fill_set_o      = set_q;
    bus.refill_done_o   = commit;
    bus.refill_err_o    = commit && err_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      tag_q   <= '0;
      set_q   <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= state_q == BEATS ? cnt_q + BEAT_W'(beat) : '0;
      if (accept) begin
        tag_q <= in_tag;
        set_q <= in_set;
        way_q <= bus.victim_way_i;
        err_q <= 1'b0;
      end else if ((beat && bus.mem_rsp_err_i) || tmo) err_q <= 1'b1;
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed refill scenarios with a queue-based expected-event scoreboard
module tb_cache_refill_ctrl;
  localparam int TAG_W = 20, SET_W = 7, WAY_W = 1;
  localparam logic [1:0] K_REQ = 2'd0, K_WR = 2'd1, K_TAG = 2'd2;
  typedef struct {logic [1:0] k; logic [63:0] v;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  cache_refill_ctrl_if bus ();
  cache_refill_ctrl #(.TIMEOUT_CYC(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", n, act, exp);
    end
  endtask
  task automatic push(input logic [1:0] k, input logic [63:0] v);
    exp_t e;
    e.k = k;
    e.v = v;
    q.push_back(e);
  endtask
  // tag-side event: {tag_we, tag_valid, tag, set, way, done, err, fill, fill_way/fill_set when filling}
  function automatic logic [63:0] tag_ev(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w,
                                         input logic [TAG_W-1:0] t, input logic cm, input logic er);
    logic ok;
    ok = cm && !er;
    return 64'({1'b1, ok, t, s, w, cm, cm && er, ok, ok ? {w, s} : 8'h00});
  endfunction
  // monitor: every observable DUT event must match the oldest expectation
  always @(negedge clk) begin : mon
    logic [1:0]  k;
    logic [63:0] a;
    logic        ev;
    exp_t        e;
    ev = 1'b1;
    k  = K_REQ;
    a  = '0;
    if (bus.mem_req_valid_o && bus.mem_req_ready_i) a = 64'(bus.mem_req_addr_o);
    else if (bus.data_we_o) begin
      k = K_WR;
      a = 64'({bus.data_set_o, bus.data_way_o, bus.data_beat_o, bus.data_wdata_o});
    end else if (bus.tag_we_o || bus.refill_done_o || bus.fill_o) begin
      k = K_TAG;
      a = 64'({bus.tag_we_o, bus.tag_valid_o, bus.tag_o, bus.data_set_o, bus.data_way_o,
               bus.refill_done_o, bus.refill_err_o, bus.fill_o,
               bus.fill_o ? {bus.fill_way_o, bus.fill_set_o} : 8'h00});
    end else ev = 1'b0;
    if (ev) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event kind=%0d got=%h expected none", k, a);
      end else begin
        e = q.pop_front();
        if (e.k !== k || e.v !== a) begin
          failures++;
          $display("FAIL event got kind=%0d val=%h expected kind=%0d val=%h", k, a, e.k, e.v);
        end
      end
    end
  end
  task automatic do_miss(input logic [31:0] addr, input logic [WAY_W-1:0] way,
                         input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t, input bit hold);
    bus.miss_valid_i = 1'b1;
    bus.miss_addr_i  = addr;
    bus.victim_way_i = way;
    chk("miss_ready_at_accept", 64'(bus.miss_ready_o), 64'd1);
    push(K_TAG, tag_ev(s, way, t, 1'b0, 1'b0));
    tick();
    if (!hold) bus.miss_valid_i = 1'b0;
  endtask
  task automatic do_req(input logic [31:0] addr, input int stall);
    for (int i = 0; i < stall; i++) begin
      chk("req_hold_valid", 64'(bus.mem_req_valid_o), 64'd1);
      chk("req_hold_addr", 64'(bus.mem_req_addr_o), 64'(addr));
      chk("req_hold_no_we", 64'(bus.data_we_o), 64'd0);
      tick();
    end
    bus.mem_req_ready_i = 1'b1;
    push(K_REQ, 64'(addr));
    tick();
    bus.mem_req_ready_i = 1'b0;
    chk("rsp_ready_in_beats", 64'(bus.mem_rsp_ready_o), 64'd1);
  endtask
  task automatic do_beats(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w, input logic [TAG_W-1:0] t,
                          input logic [31:0] base, input int gap, input int err_beat, input int n);
    for (int b = 0; b < n; b++) begin
      if (b > 0) for (int g = 0; g < gap; g++) tick();
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = base + 32'(b);
      bus.mem_rsp_err_i   = b == err_beat;
      push(K_WR, 64'({s, w, 3'(b), base + 32'(b)}));
      tick();
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_err_i   = 1'b0;
    end
    if (n == 8) begin
      chk("done_after_last_beat", 64'(bus.refill_done_o), 64'd1);
      push(K_TAG, tag_ev(s, w, t, 1'b1, err_beat < 8));
      tick();
    end
  endtask
  initial begin
    bus.miss_valid_i    = 1'b0;
    bus.miss_addr_i     = '0;
    bus.victim_way_i    = '0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
    bus.mem_rsp_err_i   = 1'b0;
    tick();
    tick();
    chk("rst_miss_ready", 64'(bus.miss_ready_o), 64'd1);
    chk("rst_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
    chk("rst_rsp_ready", 64'(bus.mem_rsp_ready_o), 64'd0);
    chk("rst_strobes", 64'({bus.data_we_o, bus.tag_we_o, bus.fill_o, bus.refill_done_o, bus.refill_err_o}), 64'd0);
    rst = 1'b0;
    tick();
    // basic refill
    do_miss(32'h0000_1234, 1'b1, 7'h11, 20'h00001, 1'b0);
    do_req(32'h0000_1220, 0);
    do_beats(7'h11, 1'b1, 20'h00001, 32'h0000_00A0, 0, 8, 8);
    // request stalled five cycles
    do_miss(32'hDEAD_BEEF, 1'b0, 7'h77, 20'hDEADB, 1'b0);
    do_req(32'hDEAD_BEE0, 5);
    do_beats(7'h77, 1'b0, 20'hDEADB, 32'h5A5A_0000, 0, 8, 8);
    // bus error on beat 3, top set
    do_miss(32'h0000_0FE0, 1'b1, 7'h7F, 20'h00000, 1'b0);
    do_req(32'h0000_0FE0, 0);
    do_beats(7'h7F, 1'b1, 20'h00000, 32'hE000_0000, 0, 3, 8);
    // gapped beats with miss_valid held: second miss taken the cycle after COMMIT
    do_miss(32'h8000_0040, 1'b0, 7'h02, 20'h80000, 1'b1);
    bus.miss_addr_i  = 32'h0000_2FFF;
    bus.victim_way_i = 1'b1;
    do_req(32'h8000_0040, 0);
    do_beats(7'h02, 1'b0, 20'h80000, 32'h4000_0000, 1, 8, 8);
    chk("miss_ready_after_commit", 64'(bus.miss_ready_o), 64'd1);
    push(K_TAG, tag_ev(7'h7F, 1'b1, 20'h00002, 1'b0, 1'b0));
    tick();
    bus.miss_valid_i = 1'b0;
    do_req(32'h0000_2FE0, 2);
    do_beats(7'h7F, 1'b1, 20'h00002, 32'h4100_0000, 2, 8, 8);
    // reset during beat 4
    do_miss(32'h0001_0000, 1'b0, 7'h00, 20'h00010, 1'b0);
    do_req(32'h0001_0000, 0);
    do_beats(7'h00, 1'b0, 20'h00010, 32'h5000_0000, 0, 8, 4);
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 32'h5000_0004;
    rst = 1'b1;
    #1;
    chk("rst_mid_no_we", 64'(bus.data_we_o), 64'd0);
    tick();
    bus.mem_rsp_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_release_ready", 64'(bus.miss_ready_o), 64'd1);
    chk("rst_release_no_done", 64'({bus.refill_done_o, bus.fill_o}), 64'd0);
    tick();
    do_miss(32'h0000_1234, 1'b0, 7'h11, 20'h00001, 1'b0);
    do_req(32'h0000_1220, 1);
    do_beats(7'h11, 1'b0, 20'h00001, 32'h6000_0000, 0, 8, 8);
`ifdef CACHE_REFILL_TIMEOUT_EN
    // no response after the request: aborted with error after 16 stalled cycles
    do_miss(32'h0000_3000, 1'b1, 7'h00, 20'h00003, 1'b0);
    do_req(32'h0000_3000, 0);
    for (int i = 0; i < 16; i++) begin
      chk("tmo_no_early_done", 64'(bus.refill_done_o), 64'd0);
      tick();
    end
    push(K_TAG, tag_ev(7'h00, 1'b1, 20'h00003, 1'b1, 1'b1));
    chk("tmo_done_err", 64'({bus.refill_done_o, bus.refill_err_o, bus.fill_o}), 64'b110);
    tick();
`endif
    repeat (3) tick();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
